lc3b_mem_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port 16-bit data memory between the instruction-fetch cache port and the MEM-stage dcache port of the LC-3b pipeline. Each requester holds a level request until it sees a one-cycle ready; the arbiter grants one transaction at a time and latches its command. It forwards the memory's ready and data back to the granted side only. It sits between the fetch/MEM stages and the memory model, and is the sole driver of the memory port.

---
 rtl/lc3b_mem_arbiter.sv | 107 ++++++++++
 tb/tb_lc3b_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_mem_arbiter.sv
// Shares one single-port 16-bit memory between the fetch (icache) and MEM-stage (dcache)
// requesters; dcache has priority, with a starvation limit that forces an icache grant.
module lc3b_mem_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        icache_en,
   input  logic [15:0] icache_addr,
   output logic        icache_r,
   output logic [15:0] icache_dout,
   input  logic        dcache_en,
   input  logic [1:0]  dcache_we,
   input  logic [15:0] dcache_addr,
   input  logic [15:0] dcache_din,
   output logic        dcache_r,
   output logic [15:0] dcache_dout,
   output logic        mem_en,
   output logic [1:0]  mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_din,
   input  logic        mem_r,
   input  logic [15:0] mem_dout,
   output logic        arb_busy,
   output logic [1:0]  arb_grant
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] I_BUSY = 2'd1;
   localparam logic [1:0] D_BUSY = 2'd2;
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [1:0]  state_q, state_d;
   logic [3:0]  starve_cnt_q, starve_cnt_d;
   logic [1:0]  mem_we_q, mem_we_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [15:0] mem_din_q, mem_din_d;
   logic        grant_d, grant_i;

   // Valid/ready: each requester holds en (and its command) until it sees a one-cycle r;
   // the command is latched at grant so later input changes never reach the memory port.
   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_din_d    = mem_din_q;
      grant_d      = 1'b0;
      grant_i      = 1'b0;
      case (state_q)
         IDLE: begin
            grant_d = dcache_en && !(icache_en && (starve_cnt_q == STARVE_LIM));
            grant_i = icache_en && !grant_d;
            if (grant_d) begin
               state_d    = D_BUSY;
               mem_we_d   = dcache_we;
               mem_addr_d = dcache_addr;
               mem_din_d  = dcache_din;
            end else if (grant_i) begin
               state_d    = I_BUSY;
               mem_we_d   = 2'b00;
               mem_addr_d = icache_addr;
               mem_din_d  = 16'h0000;
            end
            // Only a dcache grant that makes a waiting icache wait longer counts toward starvation.
            if (grant_d && icache_en) begin
               starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q : starve_cnt_q + 4'd1;
            end else begin
               starve_cnt_d = 4'd0;
            end
         end
         I_BUSY, D_BUSY: begin
            if (mem_r) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         starve_cnt_q <= 4'd0;
         mem_we_q     <= 2'b00;
         mem_addr_q   <= 16'h0000;
         mem_din_q    <= 16'h0000;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_din_q    <= mem_din_d;
      end
   end

   assign mem_en      = (state_q != IDLE);
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_din     = mem_din_q;
   assign arb_busy    = (state_q != IDLE);
   assign arb_grant   = {state_q == D_BUSY, state_q == I_BUSY};
   // A fetch dropped mid-transaction (redirect) still completes at the memory but gets no r.
   assign icache_r    = (state_q == I_BUSY) && mem_r && icache_en;
   assign dcache_r    = (state_q == D_BUSY) && mem_r;
   assign icache_dout = mem_dout;
   assign dcache_dout = mem_dout;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Bench for lc3b_mem_arbiter: directed scenarios plus randomized traffic, checked by a
// transaction-level reference model feeding expected queues that a monitor drains.
module tb_lc3b_mem_arbiter;

   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        icache_en;
   logic [15:0] icache_addr;
   logic        icache_r;
   logic [15:0] icache_dout;
   logic        dcache_en;
   logic [1:0]  dcache_we;
   logic [15:0] dcache_addr;
   logic [15:0] dcache_din;
   logic        dcache_r;
   logic [15:0] dcache_dout;
   logic        mem_en;
   logic [1:0]  mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_din;
   logic        mem_r;
   logic [15:0] mem_dout;
   logic        arb_busy;
   logic [1:0]  arb_grant;

   lc3b_mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst),
      .icache_en(icache_en), .icache_addr(icache_addr), .icache_r(icache_r), .icache_dout(icache_dout),
      .dcache_en(dcache_en), .dcache_we(dcache_we), .dcache_addr(dcache_addr), .dcache_din(dcache_din),
      .dcache_r(dcache_r), .dcache_dout(dcache_dout),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_r(mem_r), .mem_dout(mem_dout),
      .arb_busy(arb_busy), .arb_grant(arb_grant)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   logic [35:0] exp_q[$];     // {grant, we, addr, din} of each expected memory command
   logic [17:0] exp_r_q[$];   // {dcache_r, icache_r, dout} of each expected completion
   logic [1:0]  grant_log[$];
   logic [35:0] cur_cmd = '0;
   logic        prev_en = 1'b0;

   int  m_owner = 0;          // 0 none, 1 icache, 2 dcache
   int  m_starve = 0;
   int  obs_owner = 0;
   bit  take_d, take_i;
   int  mem_mode = 2;         // 0 random ready, 1 ready tied high, 2 driven by hand

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] exp_state(input int o);
      case (o)
         1:       return 4'b1101;
         2:       return 4'b1110;
         default: return 4'b0000;
      endcase
   endfunction

   // ---------------- memory model ----------------
   initial forever begin
      @(posedge clk);
      #1;
      if (mem_mode == 0) mem_r = ($urandom_range(0, 2) == 0);
      else if (mem_mode == 1) mem_r = 1'b1;
      mem_dout = 16'($urandom);
   end

   // ---------------- reference model ----------------
   initial forever begin
      @(negedge clk);
      if (rst) begin
         m_owner = 0;
         m_starve = 0;
         obs_owner = 0;
      end else begin
         obs_owner = m_owner;
         if (m_owner != 0) begin
            if (mem_r === 1'b1) begin
               if (m_owner == 2) exp_r_q.push_back({2'b10, mem_dout});
               else if (icache_en) exp_r_q.push_back({2'b01, mem_dout});
               m_owner = 0;
            end
         end else begin
            take_d = dcache_en && !(icache_en && m_starve >= STARVE_MAX);
            take_i = icache_en && !take_d;
            if (take_d) begin
               exp_q.push_back({2'b10, dcache_we, dcache_addr, dcache_din});
               m_owner = 2;
            end else if (take_i) begin
               exp_q.push_back({2'b01, 2'b00, icache_addr, 16'h0000});
               m_owner = 1;
            end
            if (take_d && icache_en) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
            else m_starve = 0;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
         check("state", {arb_busy, mem_en, arb_grant}, exp_state(obs_owner));
         if (mem_en && !prev_en) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL cmd_unexpected: got %0h want none", {arb_grant, mem_we, mem_addr, mem_din});
            end else begin
               cur_cmd = exp_q.pop_front();
               check("cmd", {arb_grant, mem_we, mem_addr, mem_din}, cur_cmd);
               grant_log.push_back(arb_grant);
            end
         end else if (mem_en) begin
            check("cmd_hold", {mem_we, mem_addr, mem_din}, cur_cmd[33:0]);
         end
         if (icache_r || dcache_r) begin
            if (exp_r_q.size() == 0) begin
               total++; bad++;
               $display("FAIL resp_unexpected: got i=%0d d=%0d want no pulse", icache_r, dcache_r);
            end else begin
               check("resp", {dcache_r, icache_r, dcache_r ? dcache_dout : icache_dout}, exp_r_q.pop_front());
            end
         end else if (exp_r_q.size() != 0) begin
            total++; bad++;
            $display("FAIL resp_missing: got no pulse want %0h", exp_r_q[0]);
            exp_r_q.delete();
         end
      end
      prev_en = mem_en;
   end

   // ---------------- drivers ----------------
   task automatic dcache_run(input int n, input int gap_max);
      for (int k = 0; k < n; k++) begin
         int cyc;
         bit done;
         dcache_en   = 1'b1;
         dcache_we   = 2'($urandom_range(0, 3));
         dcache_addr = 16'($urandom);
         dcache_din  = 16'($urandom);
         cyc = 0;
         done = 1'b0;
         while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (dcache_r) done = 1'b1;
            else if ($urandom_range(0, 3) == 0) begin
               tick();
               dcache_addr = 16'($urandom);
               dcache_din  = 16'($urandom);
            end
         end
         if (!done) begin
            total++; bad++;
            $display("FAIL dcache_timeout: got no dcache_r want one within 100 cycles");
         end
         tick();
         dcache_en = 1'b0;
         repeat ($urandom_range(0, gap_max)) tick();
      end
   endtask

   task automatic icache_run(input int n, input int gap_max, input bit abort_en);
      for (int k = 0; k < n; k++) begin
         int cyc;
         bit done, aborted;
         icache_en   = 1'b1;
         icache_addr = 16'($urandom) & 16'hFFFE;
         cyc = 0;
         done = 1'b0;
         aborted = 1'b0;
         while (!done && !aborted && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (icache_r) done = 1'b1;
            else if (abort_en && arb_grant == 2'b01 && $urandom_range(0, 4) == 0) begin
               tick();
               icache_en = 1'b0;
               aborted = 1'b1;
               cyc = 0;
               while (arb_grant == 2'b01 && cyc < 100) begin
                  @(negedge clk);
                  cyc++;
               end
            end
         end
         if (!done && !aborted) begin
            total++; bad++;
            $display("FAIL icache_timeout: got no icache_r want one within 100 cycles");
         end
         tick();
         icache_en = 1'b0;
         repeat ($urandom_range(0, gap_max)) tick();
      end
   endtask

   // ---------------- main sequence ----------------
   logic [1:0] starve_exp [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01,
                                   2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

   initial begin
      rst = 1'b1;
      icache_en = 1'b0; icache_addr = '0;
      dcache_en = 1'b0; dcache_we = '0; dcache_addr = '0; dcache_din = '0;
      mem_r = 1'b0; mem_dout = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      check("rst_mem_en", mem_en, 1'b0);
      check("rst_mem_cmd", {mem_we, mem_addr, mem_din}, 34'h0);
      check("rst_r", {icache_r, dcache_r}, 2'b00);
      check("rst_busy_grant", {arb_busy, arb_grant}, 3'b000);

      // lone dcache store, address/data change mid-transaction, 3-cycle busy
      dcache_en = 1'b1; dcache_we = 2'b11; dcache_addr = 16'h4000; dcache_din = 16'hA1B2;
      tick();
      check("store_issue", {mem_en, mem_we, mem_addr, mem_din}, {1'b1, 2'b11, 16'h4000, 16'hA1B2});
      dcache_addr = 16'h5001; dcache_din = 16'hFFFF;
      tick();
      tick();
      mem_r = 1'b1;
      #1;
      check("store_done", {dcache_r, icache_r, mem_addr}, {2'b10, 16'h4000});
      tick();
      dcache_en = 1'b0; mem_r = 1'b0;
      tick();

      // lone icache reads with a zero-wait memory
      mem_mode = 1;
      icache_run(6, 0, 1'b0);
      mem_mode = 2;
      tick();
      mem_r = 1'b0;
      tick();

      // fetch abort with a dcache request waiting behind it
      icache_en = 1'b1; icache_addr = 16'h3000;
      tick();
      icache_en = 1'b0;
      dcache_en = 1'b1; dcache_we = 2'b00; dcache_addr = 16'h6000; dcache_din = 16'h0000;
      tick();
      tick();
      mem_r = 1'b1;
      #1;
      check("abort_no_r", icache_r, 1'b0);
      tick();
      mem_r = 1'b0;
      check("abort_idle", arb_busy, 1'b0);
      tick();
      check("abort_then_d", arb_grant, 2'b10);
      mem_r = 1'b1;
      tick();
      dcache_en = 1'b0; mem_r = 1'b0;
      tick();

      // reset in the middle of a dcache transaction
      dcache_en = 1'b1; dcache_we = 2'b01; dcache_addr = 16'h7002; dcache_din = 16'h00CD;
      tick();
      tick();
      check("pre_rst_grant", arb_grant, 2'b10);
      rst = 1'b1; dcache_en = 1'b0; mem_r = 1'b1;
      #1;
      check("rst_async", {mem_en, arb_busy, arb_grant, dcache_r, icache_r}, 6'b0);
      tick();
      mem_r = 1'b0; rst = 1'b0;
      tick();
      check("post_rst", {mem_en, mem_we, mem_addr, mem_din, icache_r, dcache_r, arb_busy, arb_grant}, 40'h0);

      // starvation: both requesters hammering a zero-wait memory from a fresh count
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      grant_log.delete();
      mem_mode = 1;
      fork
         dcache_run(8, 0);
         icache_run(2, 0, 1'b0);
      join
      check("starve_len", grant_log.size(), 10);
      for (int i = 0; i < 10 && i < grant_log.size(); i++) check("starve_order", grant_log[i], starve_exp[i]);

      // randomized traffic with random memory waits and fetch aborts
      mem_mode = 0;
      fork
         dcache_run(40, 3);
         icache_run(40, 3, 1'b1);
      join
      mem_mode = 2;
      tick();
      mem_r = 1'b0;
      repeat (4) tick();
      check("cmd_queue_empty", exp_q.size(), 0);
      check("resp_queue_empty", exp_r_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish want finish before 300000 time units");
      $fatal(1, "bench timed out");
   end

endmodule
